// File: rtl/dp_bram_pkg.sv
// Shared constants for the dual-port clearable block RAM: read-during-write
// mode encodings, read latency legality, and the clear FSM state type.
package dp_bram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 3;

    function automatic bit read_latency_ok(input int rl);
        return (rl >= READ_LATENCY_MIN) && (rl <= READ_LATENCY_MAX);
    endfunction

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/bram_rd_pipe.sv
// Read data/valid delay line. Data stages only advance behind a valid, so the
// output word holds its last delivered value between strobes.
module bram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]    vld_q;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/dp_bram_clr.sv
// True dual-port RAM with byte strobes, configurable read latency and a clear
// engine that sweeps zeros through the whole array after reset or on request.
module dp_bram_clr
    import dp_bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  a_en,
    input  logic [STRB_WIDTH-1:0] a_wr_en,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic [STRB_WIDTH-1:0] b_wr_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("dp_bram_clr: READ_LATENCY must be 1..3");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("dp_bram_clr: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  boot_q;
    logic                  sweep_we;
    logic                  last_addr;

    // Handshake: an access is taken when x_en=1 and busy=0; there is no
    // backpressure, and an access offered while busy is simply dropped.
    logic                  a_acc, b_acc;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_rd, b_rd;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] din,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb[i]) begin
                r[i*8 +: 8] = din[i*8 +: 8];
            end
        end
        return r;
    endfunction

    assign busy      = (state_q == CLR_SWEEP);
    assign last_addr = &clr_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sweep_we = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clear || boot_q) begin
                    state_d = CLR_SWEEP;
                end
            end
            CLR_SWEEP: begin
                sweep_we = 1'b1;
                if (last_addr) begin
                    state_d = CLR_IDLE;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // boot_q requests the post-reset sweep; it is consumed on the first idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_q     <= (CLEAR_ON_RESET != 0);
            clr_addr_q <= '0;
        end else begin
            if (state_q == CLR_IDLE) begin
                boot_q <= 1'b0;
            end
            if (state_q == CLR_SWEEP) begin
                clr_addr_q <= last_addr ? '0 : clr_addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign a_acc = a_en & ~busy;
    assign b_acc = b_en & ~busy;
    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];
    assign a_rd  = (WRITE_MODE == WM_WRITE_FIRST) ? merge_bytes(a_old, a_din, a_wr_en) : a_old;
    assign b_rd  = (WRITE_MODE == WM_WRITE_FIRST) ? merge_bytes(b_old, b_din, b_wr_en) : b_old;

    // On a same-address collision port A owns every byte it strobes.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[clr_addr_q] <= '0;
        end else begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (b_acc && b_wr_en[i] && !(a_acc && a_wr_en[i] && (a_addr == b_addr))) begin
                    mem[b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
                end
                if (a_acc && a_wr_en[i]) begin
                    mem[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
                end
            end
        end
    end

    bram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_a_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_acc),
        .in_data   (a_rd),
        .out_valid (a_valid),
        .out_data  (a_dout)
    );

    bram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_b_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_acc),
        .in_data   (b_rd),
        .out_valid (b_valid),
        .out_data  (b_dout)
    );

endmodule

// File: tb/tb_dp_bram_clr.sv
// Bench for dp_bram_clr: a READ_FIRST/latency-3 and a WRITE_FIRST/latency-1
// instance share one stimulus stream and are checked against a word-level model.
module tb_dp_bram_clr;

    localparam int L0    = 3;
    localparam int L1    = 1;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } sb_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear;
    logic        a_en, b_en;
    logic [3:0]  a_wr_en, b_wr_en, a_addr, b_addr;
    logic [31:0] a_din, b_din;

    logic        d0_busy, d0_a_valid, d0_b_valid, d1_busy, d1_a_valid, d1_b_valid;
    logic [31:0] d0_a_dout, d0_b_dout, d1_a_dout, d1_b_dout;

    dp_bram_clr #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(L0), .WRITE_MODE(0), .CLEAR_ON_RESET(1)
    ) u_d0 (
        .clk(clk), .rst(rst), .clear(clear), .busy(d0_busy),
        .a_en(a_en), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_din(a_din),
        .a_dout(d0_a_dout), .a_valid(d0_a_valid),
        .b_en(b_en), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_din(b_din),
        .b_dout(d0_b_dout), .b_valid(d0_b_valid)
    );

    dp_bram_clr #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(L1), .WRITE_MODE(1), .CLEAR_ON_RESET(1)
    ) u_d1 (
        .clk(clk), .rst(rst), .clear(clear), .busy(d1_busy),
        .a_en(a_en), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_din(a_din),
        .a_dout(d1_a_dout), .a_valid(d1_a_valid),
        .b_en(b_en), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_din(b_din),
        .b_dout(d1_b_dout), .b_valid(d1_b_valid)
    );

    // channels: 0 = d0 port A, 1 = d0 port B, 2 = d1 port A, 3 = d1 port B
    logic [31:0] obs_dout [4];
    logic        obs_valid [4];
    assign obs_dout[0]  = d0_a_dout;
    assign obs_dout[1]  = d0_b_dout;
    assign obs_dout[2]  = d1_a_dout;
    assign obs_dout[3]  = d1_b_dout;
    assign obs_valid[0] = d0_a_valid;
    assign obs_valid[1] = d0_b_valid;
    assign obs_valid[2] = d1_a_valid;
    assign obs_valid[3] = d1_b_valid;

    // scoreboard and reference model
    sb_t         sb_q [4][$];
    logic [31:0] last_q [4];
    logic [31:0] ref_mem [DEPTH];
    int          busy_left;
    bit          boot;
    int          cyc;
    int          n_checks, n_pass, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merged(input logic [31:0] old, input logic [31:0] din,
                                           input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[i*8 +: 8] = din[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic expect_read(input int ch, input int lat, input logic [31:0] data);
        sb_t e;
        e.due  = 32'(cyc + lat);
        e.data = data;
        sb_q[ch].push_back(e);
    endtask

    // Check this cycle's outputs, then advance the model across the coming edge.
    task automatic tick();
        sb_t         e;
        logic [31:0] old_a, old_b;
        bit          acc_a, acc_b;
        chk("busy0", {31'b0, d0_busy}, 32'(busy_left > 0));
        chk("busy1", {31'b0, d1_busy}, 32'(busy_left > 0));
        for (int ch = 0; ch < 4; ch++) begin
            if (sb_q[ch].size() > 0 && sb_q[ch][0].due == 32'(cyc)) begin
                e = sb_q[ch].pop_front();
                last_q[ch] = e.data;
                chk($sformatf("valid%0d", ch), {31'b0, obs_valid[ch]}, 32'd1);
            end else begin
                chk($sformatf("valid%0d", ch), {31'b0, obs_valid[ch]}, 32'd0);
            end
            chk($sformatf("dout%0d", ch), obs_dout[ch], last_q[ch]);
        end
        if (rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                sb_q[ch].delete();
                last_q[ch] = '0;
            end
            busy_left = 0;
            boot      = 1'b1;
        end else begin
            acc_a = a_en && (busy_left == 0);
            acc_b = b_en && (busy_left == 0);
            old_a = ref_mem[a_addr];
            old_b = ref_mem[b_addr];
            if (acc_a) begin
                expect_read(0, L0, old_a);
                expect_read(2, L1, merged(old_a, a_din, a_wr_en));
            end
            if (acc_b) begin
                expect_read(1, L0, old_b);
                expect_read(3, L1, merged(old_b, b_din, b_wr_en));
            end
            if (acc_b) ref_mem[b_addr] = merged(ref_mem[b_addr], b_din, b_wr_en);
            if (acc_a) ref_mem[a_addr] = merged(ref_mem[a_addr], a_din, a_wr_en);
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                end
            end else if (boot || clear) begin
                busy_left = DEPTH;
                boot      = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // driver tasks
    task automatic drive(input logic ae, input logic [3:0] aw, input logic [3:0] aad,
                         input logic [31:0] ad, input logic be, input logic [3:0] bw,
                         input logic [3:0] bad, input logic [31:0] bd);
        a_en = ae; a_wr_en = aw; a_addr = aad; a_din = ad;
        b_en = be; b_wr_en = bw; b_addr = bad; b_din = bd;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        int nb, vcount, first_v, last_v;
        n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
        busy_left = 0; boot = 1'b1;
        for (int ch = 0; ch < 4; ch++) last_q[ch] = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst = 1'b1; clear = 1'b0;
        a_en = 0; a_wr_en = 0; a_addr = 0; a_din = 0;
        b_en = 0; b_wr_en = 0; b_addr = 0; b_din = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset values, then the automatic sweep lasts exactly DEPTH cycles
        idle(2);
        rst = 1'b0;
        nb = 0;
        repeat (20) begin
            if (d0_busy === 1'b1) nb++;
            idle(1);
        end
        chk("reset_busy_len", 32'(nb), 32'd16);

        // every address reads zero on both ports
        for (int i = 0; i < DEPTH; i++) drive(1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(15 - i), 32'h0);
        idle(4);
        chk("zero_a_d0", d0_a_dout, 32'h0);
        chk("zero_b_d1", d1_b_dout, 32'h0);

        // byte strobes
        drive(1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 4'h0, 4'h0, 32'h0);
        drive(1, 4'h5, 4'd3, 32'h11223344, 0, 4'h0, 4'h0, 32'h0);
        drive(1, 4'h0, 4'd3, 32'h0, 0, 4'h0, 4'h0, 32'h0);
        idle(4);
        chk("strobe_d0", d0_a_dout, 32'hDE22BE44);
        chk("strobe_d1", d1_a_dout, 32'hDE22BE44);

        // read-during-write, same port and cross port
        drive(1, 4'hF, 4'd5, 32'hAAAAAAAA, 0, 4'h0, 4'h0, 32'h0);
        drive(1, 4'hF, 4'd5, 32'h55555555, 1, 4'h0, 4'd5, 32'h0);
        idle(4);
        chk("rdw_rf_a", d0_a_dout, 32'hAAAAAAAA);
        chk("rdw_wf_a", d1_a_dout, 32'h55555555);
        chk("rdw_rf_b", d0_b_dout, 32'hAAAAAAAA);
        chk("rdw_wf_b", d1_b_dout, 32'hAAAAAAAA);

        // dual-write collision
        drive(1, 4'h1, 4'd7, 32'h000000FF, 1, 4'hF, 4'd7, 32'hFFFFFF00);
        drive(1, 4'h0, 4'd7, 32'h0, 0, 4'h0, 4'h0, 32'h0);
        idle(4);
        chk("collide_d0", d0_a_dout, 32'hFFFFFFFF);
        chk("collide_d1", d1_a_dout, 32'hFFFFFFFF);

        // randomized traffic on both ports
        repeat (150) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                  4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                  4'($urandom_range(0, 15)), $urandom);
        end
        idle(4);

        // clear request with a read taken in the same cycle; accesses while busy are dropped
        drive(1, 4'hF, 4'd9, 32'hCAFEF00D, 0, 4'h0, 4'h0, 32'h0);
        clear = 1'b1;
        drive(1, 4'h0, 4'd9, 32'h0, 0, 4'h0, 4'h0, 32'h0);
        clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            clear = (i == 8 || i == 15);
            drive(1, 4'hF, 4'd9, 32'h12345678 + 32'(i), 1, 4'hF, 4'd9, 32'h9ABC0000 + 32'(i));
        end
        clear = 1'b0;
        idle(2);
        drive(1, 4'h0, 4'd9, 32'h0, 1, 4'h0, 4'd9, 32'h0);
        idle(4);
        chk("busy_drop_d0", d0_a_dout, 32'h0);
        chk("busy_drop_d1", d1_b_dout, 32'h0);

        // in-flight reads flushed by reset, then reset again at sweep address 6
        drive(1, 4'hF, 4'd2, 32'h0BADF00D, 0, 4'h0, 4'h0, 32'h0);
        drive(1, 4'h0, 4'd2, 32'h0, 1, 4'h0, 4'd2, 32'h0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        nb = 0;
        repeat (20) begin
            if (d1_busy === 1'b1) nb++;
            idle(1);
        end
        chk("restart_busy_len", 32'(nb), 32'd16);

        // 8 back-to-back reads give 8 consecutive strobes, first one 3 cycles later
        for (int i = 0; i < 8; i++) drive(0, 4'h0, 4'h0, 32'h0, 1, 4'hF, 4'(i), $urandom);
        vcount = 0; first_v = -1; last_v = -1;
        for (int k = 0; k < 14; k++) begin
            if (d0_a_valid === 1'b1) begin
                vcount++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            if (k < 8) drive(1, 4'h0, 4'(k), 32'h0, 0, 4'h0, 4'h0, 32'h0);
            else       idle(1);
        end
        chk("stream_count", 32'(vcount), 32'd8);
        chk("stream_first", 32'(first_v), 32'd3);
        chk("stream_last", 32'(last_v), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dp_bram_clr.md
# dp_bram_clr

- Single-clock true-dual-port block RAM with per-byte write strobes on both ports.
- Configurable read latency with a valid strobe, selectable read-during-write mode, and a built-in clear engine that zeroes the whole array after reset or on request.
- Sits between the KAN weight/coefficient loaders and the compute datapath, which need both ports writable and a known all-zero start state.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10: address width; DEPTH = 2**ADDR_WIDTH words.
- STRB_WIDTH, DATA_WIDTH/8: byte strobes per port.
- READ_LATENCY, 1: cycles from accepted access to dout/valid; legal 1..3.
- WRITE_MODE, 0: same-port read-during-write; 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data).
- CLEAR_ON_RESET, 1: 1 = clear sweep starts automatically after reset.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle request to start a clear sweep.
- busy  out  1  high while clearing.
- a_en  in  1  port A access enable.
- a_wr_en  in  STRB_WIDTH  port A byte write strobes; all-zero means read.
- a_addr  in  ADDR_WIDTH  port A address.
- a_din  in  DATA_WIDTH  port A write data.
- a_dout  out  DATA_WIDTH  port A read data.
- a_valid  out  1  port A read data valid strobe.
- b_en, b_wr_en, b_addr, b_din, b_dout, b_valid: port B, identical to port A.

## Operation
- Access accepted when x_en=1 and busy=0. Each set strobe bit writes its byte; every accepted access also reads.
- Same-port read data:
  - WRITE_MODE=0: pre-write word.
  - WRITE_MODE=1: stored word with the strobed bytes replaced by x_din.
- Cross-port read of an address the other port writes in the same cycle always returns the pre-write word.
- Both ports write the same address in the same cycle: per byte, port A wins where its strobe is set; port B bytes with no A strobe are written.
- Clear FSM has two states:
  - IDLE -> CLEAR on clear=1, or on the first cycle after rst when CLEAR_ON_RESET=1.
  - In CLEAR, a counter 0..DEPTH-1 writes all-zero words, one per cycle.
  - CLEAR -> IDLE after address DEPTH-1 is written.
- While busy, port accesses are dropped (no write, no valid) and clear is ignored.
- Memory contents are not reset by rst; only the clear sweep zeroes them.

## Timing
- Reset values: busy=0 during rst; a_dout=b_dout=0; a_valid=b_valid=0; FSM=IDLE; counter=0.
- Read pipeline: an access accepted in cycle N gives x_valid=1 for exactly one cycle, in cycle N+READ_LATENCY, with x_dout updated in that cycle.
- x_dout holds its last valid value until the next valid strobe.
- Back-to-back accepted accesses give back-to-back valid strobes. Throughput is one access per port per cycle.
- Clear with CLEAR_ON_RESET=1:
  - rst deasserted at edge R.
  - busy=1 from cycle R+1 through R+DEPTH.
  - Zero writes to addresses 0..DEPTH-1 in cycles R+1..R+DEPTH.
  - busy=0 in cycle R+DEPTH+1; accesses are accepted from that cycle.
- Clear via the clear input: clear=1 in IDLE at cycle N gives busy=1 for cycles N+1..N+DEPTH.
- rst mid-sweep: in-flight reads are flushed (valid pipeline cleared), the counter returns to 0, and the sweep restarts from address 0 if CLEAR_ON_RESET=1, else the FSM goes to IDLE.
- Reads accepted before busy rises still deliver their valid strobe on schedule.

## Structure
- Package dp_bram_pkg holds the WRITE_MODE constants (WM_READ_FIRST=0, WM_WRITE_FIRST=1) and the READ_LATENCY legal-range check.
- Sub-module bram_rd_pipe: a READ_LATENCY-deep data/valid delay line with synchronous reset, instantiated once per port.
- Top level holds the array, the byte-merge logic, the collision priority, and the clear FSM and counter.

## Test plan
- Reset with CLEAR_ON_RESET=1 and ADDR_WIDTH=4:
  - busy=1 for exactly 16 cycles.
  - Then reading all 16 addresses on both ports returns 0x00000000.
  - a_valid is asserted READ_LATENCY cycles after each read.
- Byte strobes: write 0xDEADBEEF with strobe 0xF at addr 3, then 0x11223344 with strobe 0x5 at addr 3 -> read returns 0xDE22BE44.
- Read-during-write, addr 5 holding 0xAAAAAAAA, port A writes 0x55555555 (strobe 0xF) while reading:
  - WRITE_MODE=0: a_dout=0xAAAAAAAA.
  - WRITE_MODE=1: a_dout=0x55555555.
  - Port B reading addr 5 in the same cycle gets 0xAAAAAAAA in both modes.
- Dual-write collision at addr 7 (stored 0x00000000):
  - A writes 0x000000FF with strobe 0x1.
  - B writes 0xFFFFFF00 with strobe 0xF.
  - Result: 0xFFFFFFFF.
- Accesses during busy: writes issued while busy=1 do not land (address reads 0 afterwards) and produce no valid strobe. A clear pulse during busy does not extend the sweep.
- rst asserted at sweep address 6: valid pipeline flushes and the sweep restarts at 0. Streaming 8 back-to-back reads at READ_LATENCY=3 gives 8 consecutive valid strobes starting 3 cycles after the first.
